// File: rtl/cache_fill_ctrl.sv
// Shared I/D-cache miss fill controller: arbitrates misses, streams one block from pipelined memory, then writes the tag.
// Optional `FILL_RR_ARB_EN selects round-robin arbitration instead of fixed D-side priority.
module cache_fill_ctrl #(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              i_write_data_array,
    output logic              i_write_tag_array,
    output logic              d_write_data_array,
    output logic              d_write_tag_array,
    output logic              i_stall,
    output logic              d_stall,
    output logic              busy
);

    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_issue_cnt;
    logic [CW-1:0]     r_recv_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_owner_d;

    logic              w_any_miss;
    logic              w_grant_d;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_issue;
    logic              w_recv;
    logic              w_last_recv;

`ifdef FILL_RR_ARB_EN
    logic r_last_d;

    // On contention, serve the side that did not own the last completed fill.
    always_comb begin
        w_grant_d = dcache_miss & (~icache_miss | ~r_last_d);
    end
`else
    always_comb begin
        w_grant_d = dcache_miss;
    end
`endif

    always_comb begin
        w_any_miss   = icache_miss | dcache_miss;
        w_grant_addr = w_grant_d ? dcache_addr : icache_addr;
        w_issue      = (r_state == FILL) && (r_issue_cnt < CW'(WORDS));
        w_recv       = (r_state == FILL) && mem_data_valid;
        w_last_recv  = w_recv && (r_recv_cnt == CW'(WORDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_base      <= '0;
            r_owner_d   <= 1'b1;
`ifdef FILL_RR_ARB_EN
            r_last_d    <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_miss) begin
                        r_state     <= FILL;
                        r_base      <= w_grant_addr & ~OFF_MASK;
                        r_owner_d   <= w_grant_d;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + CW'(1);
                    end
                    if (w_recv) begin
                        r_recv_cnt <= r_recv_cnt + CW'(1);
                    end
                    if (w_last_recv) begin
                        r_state <= TAG;
                    end
                end
                TAG: begin
                    r_state     <= IDLE;
                    r_issue_cnt <= '0;
                    r_recv_cnt  <= '0;
`ifdef FILL_RR_ARB_EN
                    r_last_d    <= r_owner_d;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side and array-side strobes decode directly from state and counters.
    always_comb begin
        busy               = (r_state != IDLE);
        mem_en             = w_issue;
        mem_addr           = r_base + (ADDR_W'(r_issue_cnt) << 1);
        fill_addr          = r_base + (ADDR_W'(r_recv_cnt) << 1);
        fill_data          = mem_rdata;
        i_write_data_array = w_recv & ~r_owner_d;
        d_write_data_array = w_recv & r_owner_d;
        i_write_tag_array  = (r_state == TAG) & ~r_owner_d;
        d_write_tag_array  = (r_state == TAG) & r_owner_d;
        i_stall            = icache_miss | (busy & ~r_owner_d);
        d_stall            = dcache_miss | (busy & r_owner_d);
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed scenarios plus randomized misses, checked every cycle against a behavioural model.
module tb_cache_fill_ctrl;

    localparam int WORDS  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int SIDE_I = 0;
    localparam int SIDE_D = 1;
`ifdef FILL_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_miss, dcache_miss;
    logic [ADDR_W-1:0] icache_addr, dcache_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr, fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              i_write_data_array, i_write_tag_array;
    logic              d_write_data_array, d_write_tag_array;
    logic              i_stall, d_stall, busy;

    cache_fill_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .fill_data(fill_data), .fill_addr(fill_addr),
        .i_write_data_array(i_write_data_array), .i_write_tag_array(i_write_tag_array),
        .d_write_data_array(d_write_data_array), .d_write_tag_array(d_write_tag_array),
        .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a * 16'h3B29) ^ 16'h5A17;
    endfunction

    // Memory: pipelined, in-order returns, configurable latency and return gaps.
    typedef struct {
        logic [15:0] a;
        int          rdy;
    } req_t;
    req_t mq[$];
    int   cyc = 0;
    int   mem_lat = 4;
    int   gap_mode = 0;

    // Cache sides: queued miss addresses, popped after the side's tag write.
    logic [15:0] iq[$];
    logic [15:0] dq[$];
    bit          d_hide = 1'b0;
    bit          pop_i = 1'b0, pop_d = 1'b0;

    // Observation logs.
    logic [15:0] iss_log[$];
    logic [15:0] wr_log[$];
    int          tag_log[$];
    int          n_iw, n_dw, n_it, n_dt;

    // Behavioural model of the fill in progress.
    bit live = 1'b0;
    bit m_busy, m_tag;
    int m_owner, m_last_side, m_base, m_issued, m_recvd;

    always @(posedge clk) begin
        if (!rst) begin
            live = 1'b1;
            m_busy = 1'b0; m_tag = 1'b0; m_owner = SIDE_D; m_last_side = SIDE_D;
            m_base = 0; m_issued = 0; m_recvd = 0;
        end else if (!m_busy) begin
            if (icache_miss || dcache_miss) begin
                if (icache_miss && dcache_miss)
                    m_owner = RR ? ((m_last_side == SIDE_I) ? SIDE_D : SIDE_I) : SIDE_D;
                else
                    m_owner = dcache_miss ? SIDE_D : SIDE_I;
                m_base   = int'(m_owner == SIDE_D ? dcache_addr : icache_addr) & ~(2 * WORDS - 1);
                m_issued = 0;
                m_recvd  = 0;
                m_busy   = 1'b1;
            end
        end else if (m_tag) begin
            m_last_side = m_owner;
            m_busy = 1'b0; m_tag = 1'b0; m_issued = 0; m_recvd = 0;
        end else begin
            if (m_issued < WORDS) m_issued++;
            if (mem_data_valid) begin
                m_recvd++;
                if (m_recvd == WORDS) m_tag = 1'b1;
            end
        end
    end

    // Compare and monitor, away from the active edge.
    always @(negedge clk) begin
        bit exp_en, exp_wr;
        if (live) begin
            exp_en = m_busy && !m_tag && (m_issued < WORDS);
            exp_wr = m_busy && !m_tag && mem_data_valid;
            chk("busy", busy, m_busy);
            chk("mem_en", mem_en, exp_en);
            if (exp_en) chk("mem_addr", mem_addr, m_base + 2 * m_issued);
            chk("i_write_data_array", i_write_data_array, exp_wr && m_owner == SIDE_I);
            chk("d_write_data_array", d_write_data_array, exp_wr && m_owner == SIDE_D);
            if (exp_wr) begin
                chk("fill_addr", fill_addr, m_base + 2 * m_recvd);
                chk("fill_word", fill_data, mdata(16'(m_base + 2 * m_recvd)));
            end
            chk("fill_data", fill_data, mem_rdata);
            chk("i_write_tag_array", i_write_tag_array, m_tag && m_owner == SIDE_I);
            chk("d_write_tag_array", d_write_tag_array, m_tag && m_owner == SIDE_D);
            chk("i_stall", i_stall, icache_miss || (m_busy && m_owner == SIDE_I));
            chk("d_stall", d_stall, dcache_miss || (m_busy && m_owner == SIDE_D));
        end
        if (mem_en === 1'b1) begin
            mq.push_back('{a: mem_addr, rdy: cyc + mem_lat});
            iss_log.push_back(mem_addr);
        end
        if (i_write_data_array === 1'b1) begin n_iw++; wr_log.push_back(fill_addr); end
        if (d_write_data_array === 1'b1) begin n_dw++; wr_log.push_back(fill_addr); end
        if (i_write_tag_array === 1'b1) begin n_it++; tag_log.push_back(SIDE_I); pop_i = 1'b1; end
        if (d_write_tag_array === 1'b1) begin n_dt++; tag_log.push_back(SIDE_D); pop_d = 1'b1; end
    end

    // Input driver: one update per cycle, just after the rising edge.
    initial forever begin
        bit gap_ok;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_i) begin if (iq.size() > 0) void'(iq.pop_front()); pop_i = 1'b0; end
        if (pop_d) begin if (dq.size() > 0) void'(dq.pop_front()); pop_d = 1'b0; end
        icache_miss = (iq.size() > 0);
        icache_addr = (iq.size() > 0) ? iq[0] : 16'($urandom);
        dcache_miss = (dq.size() > 0) && !d_hide;
        dcache_addr = (dq.size() > 0) ? dq[0] : 16'($urandom);
        case (gap_mode)
            1:       gap_ok = (cyc % 2 == 0);
            2:       gap_ok = ($urandom_range(0, 2) != 0);
            default: gap_ok = 1'b1;
        endcase
        if (mq.size() > 0 && mq[0].rdy <= cyc && gap_ok) begin
            mem_data_valid = 1'b1;
            mem_rdata      = mdata(mq[0].a);
            void'(mq.pop_front());
        end else begin
            mem_data_valid = 1'b0;
            mem_rdata      = 16'($urandom);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic clear_logs();
        iss_log.delete(); wr_log.delete(); tag_log.delete();
        n_iw = 0; n_dw = 0; n_it = 0; n_dt = 0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        while ((iq.size() > 0 || dq.size() > 0 || busy !== 1'b0 || mq.size() > 0 || mem_data_valid) && k < budget) begin
            step(1);
            k++;
        end
        chk({nm, "_timeout"}, 32'(k < budget), 32'd1);
        step(2);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete(); iq.delete(); dq.delete();
        pop_i = 1'b0; pop_d = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
    endtask

    initial begin
        rst = 1'b0;
        icache_miss = 1'b0; dcache_miss = 1'b0;
        icache_addr = '0; dcache_addr = '0;
        mem_rdata = '0; mem_data_valid = 1'b0;
        clear_logs();
        step(3);
        chk("reset_busy", busy, 0);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_i_stall", i_stall, 0);
        chk("reset_d_stall", d_stall, 0);
        chk("reset_tags", {i_write_tag_array, d_write_tag_array}, 0);
        rst = 1'b1;
        step(2);

        // 1: single I miss, 4-cycle memory.
        mem_lat = 4; gap_mode = 0; clear_logs();
        iq.push_back(16'h1234);
        wait_done("s1", 200);
        chk("s1_iw", n_iw, 8);
        chk("s1_it", n_it, 1);
        chk("s1_d_strobes", n_dw + n_dt, 0);
        chk("s1_issues", iss_log.size(), 8);
        chk("s1_iss_first", iss_log[0], 16'h1230);
        chk("s1_iss_last", iss_log[7], 16'h123E);
        chk("s1_wr_first", wr_log[0], 16'h1230);
        chk("s1_wr_last", wr_log[7], 16'h123E);

        // 2: simultaneous misses right after reset.
        do_reset(); clear_logs(); mem_lat = 3;
        iq.push_back(16'h0040);
        dq.push_back(16'h8006);
        wait_done("s2", 300);
        chk("s2_tags", tag_log.size(), 2);
        chk("s2_first_owner", tag_log[0], RR ? SIDE_I : SIDE_D);
        chk("s2_first_base", wr_log[0], RR ? 16'h0040 : 16'h8000);
        chk("s2_second_base", wr_log[8], RR ? 16'h8000 : 16'h0040);

        // 3: returns every other cycle.
        clear_logs(); mem_lat = 2; gap_mode = 1;
        dq.push_back(16'h3A5C);
        wait_done("s3", 300);
        chk("s3_dw", n_dw, 8);
        chk("s3_dt", n_dt, 1);
        for (int i = 0; i < 8; i++) chk("s3_wr_order", wr_log[i], 16'h3A50 + 16'(2 * i));
        gap_mode = 0;

        // 4: reset on the third returned word of a D fill.
        clear_logs(); mem_lat = 3;
        dq.push_back(16'h7777);
        begin
            int k = 0;
            while (n_dw < 3 && k < 100) begin step(1); k++; end
            chk("s4_third_word_timeout", 32'(k < 100), 32'd1);
        end
        rst = 1'b0; dq.delete(); pop_d = 1'b0;
        step(1);
        chk("s4_abort_busy", busy, 0);
        rst = 1'b1;
        wait_done("s4_drain", 100);
        chk("s4_no_tag", n_dt, 0);
        chk("s4_partial_writes", n_dw, 3);
        clear_logs();
        dq.push_back(16'h2000);
        wait_done("s4_refill", 200);
        chk("s4_refill_dw", n_dw, 8);
        chk("s4_refill_dt", n_dt, 1);
        chk("s4_refill_base", wr_log[0], 16'h2000);

        // 5: D miss withdrawn mid-fill.
        clear_logs(); mem_lat = 2;
        dq.push_back(16'h4321);
        begin
            int k = 0;
            while (n_dw < 2 && k < 100) begin step(1); k++; end
        end
        d_hide = 1'b1;
        wait_done("s5", 200);
        d_hide = 1'b0;
        chk("s5_dw", n_dw, 8);
        chk("s5_dt", n_dt, 1);
        chk("s5_d_stall_idle", d_stall, 0);

        // 6: back-to-back D misses.
        clear_logs(); mem_lat = 1;
        dq.push_back(16'h0000);
        dq.push_back(16'h0010);
        wait_done("s6", 300);
        chk("s6_dw", n_dw, 16);
        chk("s6_dt", n_dt, 2);
        chk("s6_wr7", wr_log[7], 16'h000E);
        chk("s6_wr8", wr_log[8], 16'h0010);

        // Randomized traffic from both sides.
        for (int it = 0; it < 40; it++) begin
            int ni, nd;
            clear_logs();
            ni = 0; nd = 0;
            mem_lat  = $urandom_range(1, 6);
            gap_mode = $urandom_range(0, 2);
            for (int k = 0; k < 4; k++) begin
                step($urandom_range(0, 12));
                if ($urandom_range(0, 1) == 1) begin iq.push_back(16'($urandom)); ni++; end
                else begin dq.push_back(16'($urandom)); nd++; end
            end
            wait_done("rand", 2000);
            chk("rand_it", n_it, ni);
            chk("rand_dt", n_dt, nd);
            chk("rand_writes", n_iw + n_dw, 8 * (ni + nd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
